// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: request/response payloads and
// the source id recorded in the route FIFO.
package mem_arb_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;

    typedef logic src_id_t;

    localparam src_id_t SRC_IF = 1'b0;
    localparam src_id_t SRC_D  = 1'b1;

    function automatic src_id_t other_src(input src_id_t s);
        return ~s;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Valid/ready channel parameterised on its payload type; master drives
// valid/data, slave drives ready.
interface decoupled #(parameter type T = logic);
    logic valid;
    logic ready;
    T     data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mem_arb_route_fifo.sv
// In-order FIFO of source ids; the head is read combinationally so the
// response path adds no latency.
module route_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  src_id_t din,
    input  logic    pop,
    output src_id_t dout,
    output logic    full,
    output logic    empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    src_id_t          mem_reg [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_reg[rd_ptr_reg];

    // Storage carries no reset: entries are only meaningful below count_reg.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one memory port between fetch and data units;
// responses are steered back by the source ids queued in route_fifo.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic     clk,
    input  logic     rst,
    decoupled.slave  if_req,
    decoupled.master if_resp,
    decoupled.slave  d_req,
    decoupled.master d_resp,
    decoupled.master mem_req,
    decoupled.slave  mem_resp
);
    src_id_t last_src_reg;
    src_id_t held_src_reg;
    logic    lock_reg;

    src_id_t grant;
    logic    grant_valid;
    logic    fwd_ready;
    logic    push;
    logic    pop;
    logic    full;
    logic    empty;
    src_id_t head;

    // A stalled request keeps its grant so the mem_req payload cannot change
    // under the memory while it is waiting.
    always_comb begin
        grant = other_src(last_src_reg);
        if (lock_reg) begin
            grant = held_src_reg;
        end else if (if_req.valid && !d_req.valid) begin
            grant = SRC_IF;
        end else if (d_req.valid && !if_req.valid) begin
            grant = SRC_D;
        end
    end

    assign grant_valid   = (grant == SRC_D) ? d_req.valid : if_req.valid;
    assign mem_req.data  = (grant == SRC_D) ? d_req.data  : if_req.data;
    assign mem_req.valid = grant_valid && !full && !rst;
    assign fwd_ready     = mem_req.ready && !full && !rst;
    assign if_req.ready  = fwd_ready && (grant == SRC_IF);
    assign d_req.ready   = fwd_ready && (grant == SRC_D);
    assign push          = mem_req.valid && mem_req.ready;

    // Empty FIFO holds both response valids and mem_resp.ready low on its own.
    assign if_resp.data   = mem_resp.data;
    assign d_resp.data    = mem_resp.data;
    assign if_resp.valid  = mem_resp.valid && !empty && (head == SRC_IF);
    assign d_resp.valid   = mem_resp.valid && !empty && (head == SRC_D);
    assign mem_resp.ready = !empty && ((head == SRC_D) ? d_resp.ready : if_resp.ready);
    assign pop            = mem_resp.valid && mem_resp.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_src_reg <= SRC_D;
            held_src_reg <= SRC_IF;
            lock_reg     <= 1'b0;
        end else begin
            lock_reg     <= mem_req.valid && !mem_req.ready;
            held_src_reg <= grant;
            if (push) begin
                last_src_reg <= grant;
            end
        end
    end

    route_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_route_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (grant),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    a_no_orphan_resp : assert property (@(posedge clk) disable iff (rst)
        !(mem_resp.valid && empty));

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: queue-based sources and memory, plus a
// transaction-level model checked every cycle and literal per-test expectations.
module tb_mem_arb;
    import mem_arb_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decoupled #(.T(mem_req_t))  if_req ();
    decoupled #(.T(mem_resp_t)) if_resp ();
    decoupled #(.T(mem_req_t))  d_req ();
    decoupled #(.T(mem_resp_t)) d_resp ();
    decoupled #(.T(mem_req_t))  mem_req ();
    decoupled #(.T(mem_resp_t)) mem_resp ();

    mem_arb #(.MAX_OUTSTANDING(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_resp  (if_resp),
        .d_req    (d_req),
        .d_resp   (d_resp),
        .mem_req  (mem_req),
        .mem_resp (mem_resp)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic mem_req_t mk(input logic [31:0] addr, input logic we);
        mem_req_t r;
        r.addr  = addr;
        r.wdata = ~addr;
        r.wstrb = we ? 4'hF : 4'h0;
        r.we    = we;
        return r;
    endfunction

    function automatic mem_resp_t mem_model(input mem_req_t r);
        mem_resp_t s;
        s.rdata = r.we ? 32'h0 : (r.addr ^ 32'h5A5A_0000);
        s.err   = r.we;
        return s;
    endfunction

    // ---------------- stimulus: sources, sinks, memory ----------------
    mem_req_t  if_q[$];
    mem_req_t  d_q[$];
    mem_resp_t mq[$];
    bit        mem_rdy    = 1'b1;
    int        mem_budget = -1;
    bit        if_rr      = 1'b1;
    bit        d_rr       = 1'b1;

    logic     if_fire, d_fire, mreq_fire, mresp_fire;
    mem_req_t mreq_data;

    always @(negedge clk) begin
        if_fire    = if_req.valid && if_req.ready;
        d_fire     = d_req.valid && d_req.ready;
        mreq_fire  = mem_req.valid && mem_req.ready;
        mresp_fire = mem_resp.valid && mem_resp.ready;
        mreq_data  = mem_req.data;
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            mq.delete();
        end else begin
            if (if_fire && if_q.size() > 0) void'(if_q.pop_front());
            if (d_fire && d_q.size() > 0) void'(d_q.pop_front());
            if (mresp_fire && mq.size() > 0) begin
                void'(mq.pop_front());
                if (mem_budget > 0) mem_budget--;
            end
            if (mreq_fire) mq.push_back(mem_model(mreq_data));
        end
        if_req.valid   = (if_q.size() > 0);
        if_req.data    = (if_q.size() > 0) ? if_q[0] : '0;
        d_req.valid    = (d_q.size() > 0);
        d_req.data     = (d_q.size() > 0) ? d_q[0] : '0;
        mem_req.ready  = mem_rdy;
        mem_resp.valid = (mq.size() > 0) && (mem_budget != 0) && !rst;
        mem_resp.data  = (mq.size() > 0) ? mq[0] : '0;
        if_resp.ready  = if_rr;
        d_resp.ready   = d_rr;
    end

    // ---------------- reference model + per-cycle compare ----------------
    src_id_t m_last;
    bit      m_lock;
    src_id_t m_lock_src;
    src_id_t m_q[$];
    int      cyc = 0;

    src_id_t     g_log[$];
    int          g_cyc[$];
    src_id_t     r_log[$];
    logic [31:0] r_data[$];
    int          r_cyc[$];
    int          stall_cnt = 0;

    always @(negedge clk) begin
        src_id_t     g;
        logic        e_mv, e_ifr, e_dr, e_mrr, e_ifv, e_dv, m_full, m_empty;
        mem_req_t    e_data;
        cyc++;
        if (rst) begin
            chk("reset_outputs",
                128'({mem_req.valid, if_req.ready, d_req.ready, mem_resp.ready, if_resp.valid, d_resp.valid}),
                128'(0));
            m_last = SRC_D;
            m_lock = 1'b0;
            m_q.delete();
        end else begin
            m_full  = (m_q.size() == DEPTH);
            m_empty = (m_q.size() == 0);
            if (m_lock)                            g = m_lock_src;
            else if (if_req.valid && !d_req.valid) g = SRC_IF;
            else if (d_req.valid && !if_req.valid) g = SRC_D;
            else                                   g = (m_last == SRC_IF) ? SRC_D : SRC_IF;
            e_mv   = ((g == SRC_D) ? d_req.valid : if_req.valid) && !m_full;
            e_data = (g == SRC_D) ? d_req.data : if_req.data;
            e_ifr  = (g == SRC_IF) && mem_req.ready && !m_full;
            e_dr   = (g == SRC_D) && mem_req.ready && !m_full;
            e_ifv  = !m_empty && mem_resp.valid && (m_q[0] == SRC_IF);
            e_dv   = !m_empty && mem_resp.valid && (m_q[0] == SRC_D);
            e_mrr  = !m_empty && ((m_q[0] == SRC_D) ? d_resp.ready : if_resp.ready);

            chk("req_side", 128'({mem_req.valid, if_req.ready, d_req.ready}), 128'({e_mv, e_ifr, e_dr}));
            if (e_mv) chk("req_data", 128'(mem_req.data), 128'(e_data));
            chk("resp_side", 128'({mem_resp.ready, if_resp.valid, d_resp.valid}), 128'({e_mrr, e_ifv, e_dv}));
            chk("resp_data", 128'({if_resp.data, d_resp.data}), 128'({mem_resp.data, mem_resp.data}));

            if (e_mv && !mem_req.ready) stall_cnt++;
            if (mem_resp.valid && e_mrr) begin
                r_log.push_back(m_q[0]);
                r_data.push_back(mem_resp.data.rdata);
                r_cyc.push_back(cyc);
                $display("resp  cyc=%0d dst=%0d rdata=%h", cyc, m_q[0], mem_resp.data.rdata);
                void'(m_q.pop_front());
            end
            if (e_mv && mem_req.ready) begin
                m_q.push_back(g);
                m_last = g;
                g_log.push_back(g);
                g_cyc.push_back(cyc);
                $display("grant cyc=%0d src=%0d addr=%h", cyc, g, e_data.addr);
            end
            m_lock     = e_mv && !mem_req.ready;
            m_lock_src = g;
        end
    end

    // ---------------- directed sequence ----------------
    task automatic clear_logs();
        g_log.delete(); g_cyc.delete();
        r_log.delete(); r_data.delete(); r_cyc.delete();
        stall_cnt = 0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (!(if_q.size() == 0 && d_q.size() == 0 && mq.size() == 0 && m_q.size() == 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL %s: idle timeout after %0d cycles", name, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_count(input string name, input int want, input bit use_grant, input int max);
        int n = 0;
        while (((use_grant ? g_log.size() : r_log.size()) < want) && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL %s: count wait timeout, got %0d want %0d", name,
                     use_grant ? g_log.size() : r_log.size(), want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        if_req.valid = 1'b0;  if_req.data = '0;
        d_req.valid  = 1'b0;  d_req.data  = '0;
        mem_req.ready  = 1'b1;
        mem_resp.valid = 1'b0; mem_resp.data = '0;
        if_resp.ready = 1'b1;  d_resp.ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Both sources every cycle: strict alternation, IF first after reset
        @(negedge clk);
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            if_q.push_back(mk(32'h100 + 32'(4 * i), 1'b0));
            d_q.push_back(mk(32'h200 + 32'(4 * i), i == 2));
        end
        wait_idle("t2", 100);
        chk("t2_ngrant", 128'(g_log.size()), 128'(8));
        for (int i = 0; i < 8; i++) begin
            chk("t2_grant", 128'(g_log[i]), 128'(i % 2));
            chk("t2_route", 128'(r_log[i]), 128'(i % 2));
        end
        chk("t2_d_write_rdata", 128'(r_data[5]), 128'(0));

        // Fetch only, 1-cycle memory
        clear_logs();
        for (int i = 0; i < 3; i++) if_q.push_back(mk(32'(4 * i), 1'b0));
        wait_idle("t1", 50);
        chk("t1_nresp", 128'(r_log.size()), 128'(3));
        chk("t1_rdata0", 128'(r_data[0]), 128'(32'h5A5A_0000));
        chk("t1_rdata1", 128'(r_data[1]), 128'(32'h5A5A_0004));
        chk("t1_rdata2", 128'(r_data[2]), 128'(32'h5A5A_0008));
        for (int i = 0; i < 3; i++) chk("t1_route", 128'(r_log[i]), 128'(SRC_IF));

        // D granted (last was IF), memory stalls 3 cycles: grant and payload hold
        clear_logs();
        mem_rdy = 1'b0;
        if_q.push_back(mk(32'h300, 1'b0));
        d_q.push_back(mk(32'h400, 1'b1));
        repeat (3) @(negedge clk);
        chk("t3_hold_addr", 128'(mem_req.data.addr), 128'(32'h400));
        chk("t3_if_blocked", 128'(if_req.ready), 128'(0));
        mem_rdy = 1'b1;
        wait_idle("t3", 50);
        chk("t3_stalls", 128'(stall_cnt), 128'(3));
        chk("t3_first", 128'(g_log[0]), 128'(SRC_D));
        chk("t3_second", 128'(g_log[1]), 128'(SRC_IF));
        chk("t3_back_to_back", 128'(g_cyc[1] - g_cyc[0]), 128'(1));

        // FIFO full: 4 accepted, 5th waits for the cycle after a pop
        clear_logs();
        mem_budget = 0;
        for (int i = 0; i < 5; i++) if_q.push_back(mk(32'h500 + 32'(4 * i), 1'b0));
        repeat (10) @(negedge clk);
        chk("t4_accepted", 128'(g_log.size()), 128'(4));
        chk("t4_full_block", 128'({mem_req.valid, if_req.ready}), 128'(0));
        mem_budget = 1;
        wait_count("t4_pop", 1, 1'b0, 20);
        wait_count("t4_fifth", 5, 1'b1, 20);
        chk("t4_no_bypass", 128'(g_cyc[4] - r_cyc[0]), 128'(1));
        mem_budget = -1;
        wait_idle("t4", 50);
        chk("t4_nresp", 128'(r_log.size()), 128'(5));

        // D response held at head by d_resp.ready = 0
        clear_logs();
        d_rr = 1'b0;
        d_q.push_back(mk(32'h600, 1'b0));
        if_q.push_back(mk(32'h700, 1'b0));
        repeat (5) @(negedge clk);
        chk("t5_held", 128'({mem_resp.ready, d_resp.valid, if_resp.valid}), 128'(3'b010));
        chk("t5_none_yet", 128'(r_log.size()), 128'(0));
        d_rr = 1'b1;
        wait_idle("t5", 50);
        chk("t5_first_dst", 128'(r_log[0]), 128'(SRC_D));
        chk("t5_second_dst", 128'(r_log[1]), 128'(SRC_IF));
        chk("t5_second_rdata", 128'(r_data[1]), 128'(32'h5A5A_0700));

        // Reset with 3 outstanding and a stalled D grant
        clear_logs();
        mem_budget = 0;
        for (int i = 0; i < 3; i++) if_q.push_back(mk(32'h800 + 32'(4 * i), 1'b0));
        wait_count("t6_fill", 3, 1'b1, 20);
        mem_rdy = 1'b0;
        if_q.push_back(mk(32'h900, 1'b0));
        d_q.push_back(mk(32'hA00, 1'b0));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_immediate",
            128'({mem_req.valid, if_req.ready, d_req.ready, mem_resp.ready, if_resp.valid, d_resp.valid}),
            128'(0));
        repeat (2) @(negedge clk);
        clear_logs();
        mem_budget = -1;
        mem_rdy    = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        wait_idle("t6", 50);
        chk("t6_first_tie", 128'(g_log[0]), 128'(SRC_IF));
        chk("t6_second", 128'(g_log[1]), 128'(SRC_D));
        chk("t6_nresp", 128'(r_log.size()), 128'(2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port memory arbiter that lets the instruction-fetch and data-access units of the `cpu` core share its single `decoupled` memory port. It selects one upstream request per cycle with round-robin priority and records the source of every accepted request in an in-order route FIFO. Each memory response is returned to the requester that issued the matching request. The block sits between the core's fetch/LSU front ends and the `mem_req`/`mem_resp` port.

## Interface
- `MAX_OUTSTANDING`, default 4: route FIFO depth, i.e. the maximum number of requests in flight downstream. Must be a power of two, ≥ 2.
- `clk` in, 1: clock.
- `rst` in, 1: reset, asynchronous, active-high.
- `if_req` decoupled.in, `mem_req_t`: fetch request (source 0).
- `if_resp` decoupled.out, `mem_resp_t`: fetch response.
- `d_req` decoupled.in, `mem_req_t`: data request (source 1).
- `d_resp` decoupled.out, `mem_resp_t`: data response.
- `mem_req` decoupled.out, `mem_req_t`: request to memory.
- `mem_resp` decoupled.in, `mem_resp_t`: response from memory.

## Operation
- Decoupled rules:
  - A transfer occurs when `valid && ready` at a rising edge of `clk`.
  - A source holding `valid` keeps it and its payload stable until the transfer.
- Memory contract:
  - Every request, read or write, yields exactly one response.
  - Responses return in request order.
- Grant:
  - Only one requester valid: grant it.
  - Both requesters valid: grant the source not in `last_src`.
  - `last_src` resets to 1, so fetch wins the first tie.
- Lock: if `mem_req.valid && !mem_req.ready`, the current grant is held next cycle regardless of the other source. This keeps `mem_req` payload stable.
- Forwarding:
  - `mem_req.data` = granted payload.
  - `mem_req.valid` = granted valid && !full.
  - Granted `ready` = `mem_req.ready && !full`.
  - Non-granted `ready` = 0.
- Request transfer on `mem_req`: push the granted source id into the route FIFO and set `last_src` to it.
- Response routing:
  - FIFO head selects the destination: 0 → `if_resp`, 1 → `d_resp`.
  - `mem_resp.data` is copied to both response ports.
  - Only the selected port sees `valid`.
  - `mem_resp.ready` = selected port's `ready` && !empty.
- Response transfer on `mem_resp`: pop the FIFO.
- Empty FIFO:
  - `mem_resp.ready` = 0.
  - Both response `valid` = 0.
  - A `mem_resp.valid` arriving while empty is a protocol violation; flag it with a simulation assertion.
- Full FIFO:
  - `mem_req.valid` = 0 and both upstream `ready` = 0.
  - No bypass: a pop in the same cycle does not enable a push. This keeps request `ready` independent of response-side `ready`.
- Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
- Pointers: wrap modulo `MAX_OUTSTANDING`. Count is `$clog2(MAX_OUTSTANDING)+1` bits.

## Timing
- Request path is combinational: zero added latency from upstream `valid` to `mem_req.valid`.
- Response path is combinational: zero added latency from `mem_resp.valid` to the selected response `valid`.
- Registered state: FIFO storage and pointers, count, `last_src`, lock flag.
- While `rst` is high:
  - All `valid` and `ready` outputs are 0.
  - FIFO is empty, `last_src` = 1, lock = 0.
- Reset mid-operation:
  - In-flight route entries are discarded.
  - The memory side must be reset in the same cycle.
- First grant is possible in the first cycle after `rst` deasserts.

## Structure
- `types.sv` package gains:
  - `mem_req_t`: `addr[31:0]`, `wdata[31:0]`, `wstrb[3:0]`, `we`.
  - `mem_resp_t`: `rdata[31:0]`, `err`.
  - `src_id_t`: 1 bit, with constants `SRC_IF` = 0 and `SRC_D` = 1.
- `decoupled` is parameterised on payload type.
- One sub-module: `route_fifo`, a synchronous FIFO of `src_id_t`.
  - Parameter: `DEPTH`.
  - Ports: `push`, `din`, `pop`, `dout`, `full`, `empty`.
  - Push/pop are qualified internally by full/empty.
- The grant/lock logic stays in `mem_arb`.

## Test plan
- Fetch only, addr 0x0, 0x4, 0x8, memory always ready, 1-cycle response: three `if_resp` transfers with matching `rdata`; `d_resp.valid` never asserted.
- Both valid every cycle, memory always ready: grants alternate IF, D, IF, D starting with IF after reset; responses route in the same alternation.
- D granted with `mem_req.ready` = 0 for 3 cycles while IF is valid: grant and payload held; D transfers on cycle 4; IF is granted next.
- `MAX_OUTSTANDING` = 4, no responses, 5 requests: 4 accepted, then `mem_req.valid` = 0. One response frees a slot; the 5th request is accepted the cycle after the pop, not during it.
- `d_resp.ready` = 0 with a D response at the FIFO head: `mem_resp.ready` = 0 and the head is held. Releasing `ready` delivers it; the next IF response then routes to `if_resp`.
- `rst` asserted with 3 requests outstanding: all outputs 0 immediately; after release the FIFO is empty and the first tie goes to IF.
